frame_buffer_port: RTL and testbench

Memory-side responder for the alpha blender's pixel read/write interface. Accepts per-pixel read and write requests addressed by pixel_number and buffers them in a small command FIFO. Translates them into 32-bit word transactions on an Avalon-MM-style master port to the external frame memory. Owns double buffering: on the blender's end-of-frame signal it drains outstanding traffic, swaps the front and back buffers, and re-grants frame_ready.

---
 rtl/frame_buffer_port.sv | 254 +++++++++++++++++++++++++
 tb/tb_frame_buffer_port.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_port.sv
// ---------------------------------------------------------------------------
// frame_buffer_port
//
// Memory-side responder for the alpha blender's pixel interface. Per-pixel
// read/write requests are queued in a small command FIFO and replayed as
// 32-bit word transactions on an Avalon-MM-style master. The block also owns
// double buffering: an end-of-frame pulse drains outstanding traffic, swaps
// front and back buffers and then re-grants frame_ready.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   pixel_number          pixel index of the request (19 bits)
//   read, write           request strobes, at most one request per cycle
//   write_r/g/b           colour for write requests
//   read_r/g/b            returned colour, valid with read_valid
//   read_valid            one-cycle read return pulse
//   cmd_full              FIFO full; the requester must not strobe
//   o_frame_ready         blender end-of-frame pulse
//   frame_ready           back buffer writable, a new frame may start
//   front_base            byte base address of the displayed buffer
//   proto_err             sticky protocol-violation flag
//   avm_*                 Avalon-MM master towards the frame memory
// ---------------------------------------------------------------------------
module frame_buffer_port #(
    parameter int unsigned PIXELS     = 307200,
    parameter logic [31:0] BUF0_BASE  = 32'h0000_0000,
    parameter logic [31:0] BUF1_BASE  = 32'h0012_C000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] pixel_number,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  write_r,
    input  logic [7:0]  write_g,
    input  logic [7:0]  write_b,
    output logic [7:0]  read_r,
    output logic [7:0]  read_g,
    output logic [7:0]  read_b,
    output logic        read_valid,
    output logic        cmd_full,
    input  logic        o_frame_ready,
    output logic        frame_ready,
    output logic [31:0] front_base,
    output logic        proto_err,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic        avm_waitrequest
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic        is_write;
        logic        in_range;
        logic [31:0] addr;
        logic [23:0] rgb;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_SWAP
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             rd_pending;   // one bus read issued, data not yet back
    logic             sel;          // 0: front=BUF0/back=BUF1, 1: reversed
    state_t           state;
    state_t           state_next;

    // -----------------------------------------------------------------------
    // Request side
    // -----------------------------------------------------------------------
    logic        strobe;
    logic        enq;
    logic [31:0] back_base;
    cmd_t        new_cmd;

    assign strobe    = read | write;
    assign enq       = strobe && (state == ST_RUN) && !cmd_full;
    assign back_base = sel ? BUF0_BASE : BUF1_BASE;

    // A simultaneous read+write is queued as the write; the read is dropped.
    always_comb begin
        new_cmd          = '0;
        new_cmd.is_write = write;
        new_cmd.in_range = (32'(pixel_number) < PIXELS);
        new_cmd.addr     = back_base + {11'b0, pixel_number, 2'b00};
        new_cmd.rgb      = {write_r, write_g, write_b};
    end

    // -----------------------------------------------------------------------
    // Issue side: the bus command is taken straight from the FIFO head, so it
    // is stable for as long as waitrequest keeps the head from popping.
    // -----------------------------------------------------------------------
    cmd_t head;
    logic fifo_empty;
    logic head_ready;
    logic cmd_valid;
    logic pop;
    logic pop_oor;
    logic pop_rd;

    assign head       = fifo_mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign head_ready = !fifo_empty && !rd_pending;
    assign cmd_valid  = head_ready && head.in_range;
    // Out-of-range entries retire immediately without touching the bus.
    assign pop        = head_ready && (!head.in_range || !avm_waitrequest);
    assign pop_oor    = pop && !head.in_range;
    assign pop_rd     = pop && head.in_range && !head.is_write;

    assign avm_read      = cmd_valid && !head.is_write;
    assign avm_write     = cmd_valid && head.is_write;
    assign avm_address   = cmd_valid ? head.addr : 32'h0;
    assign avm_writedata = (cmd_valid && head.is_write) ? {8'h00, head.rgb} : 32'h0;

    // -----------------------------------------------------------------------
    // Command FIFO
    // -----------------------------------------------------------------------
    always_comb begin
        count_next = count;
        unique case ({enq, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cmd_full <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            cmd_full <= (count_next == FULL_CNT);
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // ever read after it has been written, and count gates every use.
    always_ff @(posedge clk) begin
        if (enq) fifo_mem[wr_ptr] <= new_cmd;
    end

    // -----------------------------------------------------------------------
    // Read tracking and return
    // -----------------------------------------------------------------------
    logic rd_return;
    logic unused_rdata_hi;

    // readdatavalid is only honoured while a read is actually outstanding,
    // which also discards a slave's late response after a reset.
    assign rd_return       = rd_pending && avm_readdatavalid;
    assign unused_rdata_hi = ^avm_readdata[31:24];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pending <= 1'b0;
        end else if (pop_rd) begin
            rd_pending <= 1'b1;
        end else if (rd_return) begin
            rd_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_valid <= 1'b0;
            read_r     <= 8'h00;
            read_g     <= 8'h00;
            read_b     <= 8'h00;
        end else begin
            read_valid <= rd_return || (pop_oor && !head.is_write);
            if (rd_return) begin
                read_r <= avm_readdata[23:16];
                read_g <= avm_readdata[15:8];
                read_b <= avm_readdata[7:0];
            end else if (pop_oor && !head.is_write) begin
                read_r <= 8'h00;
                read_g <= 8'h00;
                read_b <= 8'h00;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Protocol error: both strobes at once, strobe while not accepting, or an
    // out-of-range command reaching the head of the FIFO.
    // -----------------------------------------------------------------------
    logic err_set;

    assign err_set = (read && write) || (strobe && !enq) || pop_oor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (err_set) begin
            proto_err <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Frame FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
            sel   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_SWAP) sel <= ~sel;
        end
    end

    // NOTE: next-state defaults are assigned first so no path through the
    // case leaves state_next unassigned and infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_RUN:   if (o_frame_ready) state_next = ST_DRAIN;
            // The bus command is derived from the FIFO head, so an empty FIFO
            // with no read outstanding also means the bus is idle.
            ST_DRAIN: if (fifo_empty && !rd_pending) state_next = ST_SWAP;
            ST_SWAP:  state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    assign frame_ready = (state == ST_RUN);
    assign front_base  = sel ? BUF1_BASE : BUF0_BASE;

endmodule

// File: tb/tb_frame_buffer_port.sv
module tb_frame_buffer_port;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [18:0] pixel_number = '0;
    logic        read = 1'b0, write = 1'b0;
    logic [7:0]  write_r = '0, write_g = '0, write_b = '0;
    logic [7:0]  read_r, read_g, read_b;
    logic        read_valid, cmd_full;
    logic        o_frame_ready = 1'b0;
    logic        frame_ready;
    logic [31:0] front_base;
    logic        proto_err;
    logic [31:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        avm_waitrequest = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    frame_buffer_port dut (
        .clk              (clk),
        .reset            (reset),
        .pixel_number     (pixel_number),
        .read             (read),
        .write            (write),
        .write_r          (write_r),
        .write_g          (write_g),
        .write_b          (write_b),
        .read_r           (read_r),
        .read_g           (read_g),
        .read_b           (read_b),
        .read_valid       (read_valid),
        .cmd_full         (cmd_full),
        .o_frame_ready    (o_frame_ready),
        .frame_ready      (frame_ready),
        .front_base       (front_base),
        .proto_err        (proto_err),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_write        (avm_write),
        .avm_writedata    (avm_writedata),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest  (avm_waitrequest)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [18:0] pix;
        logic [23:0] rgb;
        logic        rdv;
        logic [31:0] rdata;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_rv;
        logic [23:0] e_rgb;
        logic        e_full;
        logic        e_perr;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [18:0] pix,
                                input logic [23:0] rgb, input logic rdv, input logic [31:0] rdata,
                                input logic e_rd, input logic e_wr, input logic [31:0] e_addr,
                                input logic [31:0] e_wdata, input logic e_rv, input logic [23:0] e_rgb,
                                input logic e_full, input logic e_perr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.pix = pix; v.rgb = rgb; v.rdv = rdv; v.rdata = rdata;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_rv = e_rv; v.e_rgb = e_rgb; v.e_full = e_full; v.e_perr = e_perr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        read = 1'b0; write = 1'b0; o_frame_ready = 1'b0;
        avm_readdatavalid = 1'b0;
    endtask

    task automatic set_write(input logic [18:0] pix, input logic [23:0] rgb);
        write = 1'b1; pixel_number = pix;
        {write_r, write_g, write_b} = rgb;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".read_rgb"},    {8'h0, read_r, read_g, read_b}, 32'h0);
        check({tag, ".read_valid"},  32'(read_valid), 32'h0);
        check({tag, ".cmd_full"},    32'(cmd_full), 32'h0);
        check({tag, ".frame_ready"}, 32'(frame_ready), 32'h1);
        check({tag, ".front_base"},  front_base, 32'h0);
        check({tag, ".proto_err"},   32'(proto_err), 32'h0);
        check({tag, ".avm_read"},    32'(avm_read), 32'h0);
        check({tag, ".avm_write"},   32'(avm_write), 32'h0);
        check({tag, ".avm_address"}, avm_address, 32'h0);
        check({tag, ".avm_wdata"},   avm_writedata, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Rows are one cycle each: inputs applied, clock edge, outputs compared.
    initial begin
        logic [31:0] base1;
        logic [23:0] bp_rgb [4];
        bit          seen;
        base1 = 32'h0012_C000;

        //         rd wr pix     rgb         rdv rdata          e_rd e_wr e_addr       e_wdata       e_rv e_rgb      full perr
        vecs[0]  = mk(0, 0, 19'd0,      24'h0,      0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 24'h0,      0, 0);
        vecs[1]  = mk(0, 1, 19'd5,      24'h123456, 0, 32'h0,         0, 1, 32'h0012_C014, 32'h0012_3456, 0, 24'h0,      0, 0);
        vecs[2]  = mk(0, 0, 19'd0,      24'h0,      0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 24'h0,      0, 0);
        vecs[3]  = mk(1, 0, 19'd5,      24'h0,      0, 32'h0,         1, 0, 32'h0012_C014, 32'h0,        0, 24'h0,      0, 0);
        vecs[4]  = mk(0, 0, 19'd0,      24'h0,      0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 24'h0,      0, 0);
        vecs[5]  = mk(0, 0, 19'd0,      24'h0,      0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 24'h0,      0, 0);
        vecs[6]  = mk(0, 0, 19'd0,      24'h0,      1, 32'hFF12_3456, 0, 0, 32'h0,        32'h0,        1, 24'h123456, 0, 0);
        vecs[7]  = mk(0, 0, 19'd0,      24'h0,      0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 24'h0,      0, 0);
        vecs[8]  = mk(1, 0, 19'd307200, 24'h0,      0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 24'h0,      0, 0);
        vecs[9]  = mk(0, 0, 19'd0,      24'h0,      0, 32'h0,         0, 0, 32'h0,        32'h0,        1, 24'h0,      0, 1);
        vecs[10] = mk(0, 0, 19'd0,      24'h0,      0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 24'h0,      0, 1);

        // Asynchronous reset: outputs must settle before any clock edge.
        #2 reset = 1'b1;
        #1 check_reset_values("async_reset");
        tick();
        reset = 1'b0;
        tick();

        // Write/read round trip and out-of-range read.
        for (int i = 0; i < NVEC; i++) begin
            read = vecs[i].rd; write = vecs[i].wr; pixel_number = vecs[i].pix;
            {write_r, write_g, write_b} = vecs[i].rgb;
            avm_readdatavalid = vecs[i].rdv; avm_readdata = vecs[i].rdata;
            avm_waitrequest = 1'b0;
            tick();
            check($sformatf("v%0d.avm_read", i),   32'(avm_read),   32'(vecs[i].e_rd));
            check($sformatf("v%0d.avm_write", i),  32'(avm_write),  32'(vecs[i].e_wr));
            if (vecs[i].e_rd || vecs[i].e_wr)
                check($sformatf("v%0d.avm_address", i), avm_address, vecs[i].e_addr);
            if (vecs[i].e_wr)
                check($sformatf("v%0d.avm_wdata", i), avm_writedata, vecs[i].e_wdata);
            check($sformatf("v%0d.read_valid", i), 32'(read_valid), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv)
                check($sformatf("v%0d.read_rgb", i), {8'h0, read_r, read_g, read_b}, {8'h0, vecs[i].e_rgb});
            check($sformatf("v%0d.cmd_full", i),   32'(cmd_full),   32'(vecs[i].e_full));
            check($sformatf("v%0d.proto_err", i),  32'(proto_err),  32'(vecs[i].e_perr));
        end
        idle_inputs();

        // Backpressure: 4 writes fill the FIFO behind a stalled slave.
        do_reset();
        avm_waitrequest = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bp_rgb[k] = 24'h010203 * 24'(k + 1);
            set_write(19'(10 + k), bp_rgb[k]);
            tick();
            check($sformatf("bp.full_after_%0d", k), 32'(cmd_full), (k == 3) ? 32'h1 : 32'h0);
        end
        check("bp.proto_err_before", 32'(proto_err), 32'h0);
        set_write(19'd14, 24'hEEEEEE);
        tick();
        check("bp.proto_err_overflow", 32'(proto_err), 32'h1);
        write = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp.hold_write_%0d", c), 32'(avm_write), 32'h1);
            check($sformatf("bp.hold_addr_%0d", c), avm_address, base1 + 32'd40);
            check($sformatf("bp.hold_data_%0d", c), avm_writedata, {8'h0, bp_rgb[0]});
            tick();
        end
        avm_waitrequest = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp.drain_write_%0d", k), 32'(avm_write), 32'h1);
            check($sformatf("bp.drain_addr_%0d", k), avm_address, base1 + 32'(4 * (10 + k)));
            check($sformatf("bp.drain_data_%0d", k), avm_writedata, {8'h0, bp_rgb[k]});
            tick();
        end
        check("bp.no_fifth_write", 32'(avm_write), 32'h0);
        check("bp.full_cleared", 32'(cmd_full), 32'h0);

        // Frame swap: third write arrives in the same cycle as o_frame_ready.
        avm_waitrequest = 1'b1;
        set_write(19'd20, 24'h202020); tick();
        set_write(19'd21, 24'h212121); tick();
        set_write(19'd22, 24'h222222); o_frame_ready = 1'b1; tick();
        idle_inputs();
        check("swap.frame_ready_low", 32'(frame_ready), 32'h0);
        avm_waitrequest = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("swap.drain_addr_%0d", k), avm_address, base1 + 32'(4 * (20 + k)));
            check($sformatf("swap.drain_write_%0d", k), 32'(avm_write), 32'h1);
            check($sformatf("swap.fr_low_%0d", k), 32'(frame_ready), 32'h0);
            tick();
        end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (frame_ready) seen = 1'b1;
            else tick();
        end
        check("swap.frame_ready_regrant", 32'(seen), 32'h1);
        check("swap.front_base", front_base, 32'h0012_C000);
        set_write(19'd0, 24'h0A0B0C); tick();
        write = 1'b0;
        check("swap.new_back_write", 32'(avm_write), 32'h1);
        check("swap.new_back_addr", avm_address, 32'h0000_0000);
        tick();

        // Reset while a read is held by waitrequest.
        avm_waitrequest = 1'b1;
        read = 1'b1; pixel_number = 19'd3; tick();
        read = 1'b0;
        check("rst.read_issued", 32'(avm_read), 32'h1);
        check("rst.read_addr", avm_address, 32'h0000_000C);
        tick();
        check("rst.read_held", 32'(avm_read), 32'h1);
        reset = 1'b1;
        #1 check_reset_values("mid_reset");
        tick();
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        tick();
        avm_readdatavalid = 1'b1; avm_readdata = 32'h00FF00FF;
        tick();
        avm_readdatavalid = 1'b0;
        check("rst.late_rdv_ignored", 32'(read_valid), 32'h0);
        tick();
        check("rst.late_rdv_ignored2", 32'(read_valid), 32'h0);

        // Simultaneous read+write: only the write reaches the bus.
        read = 1'b1; set_write(19'd7, 24'hAABBCC); tick();
        idle_inputs();
        check("rw.avm_write", 32'(avm_write), 32'h1);
        check("rw.avm_read", 32'(avm_read), 32'h0);
        check("rw.addr", avm_address, 32'h0012_C01C);
        check("rw.wdata", avm_writedata, 32'h00AA_BBCC);
        check("rw.proto_err", 32'(proto_err), 32'h1);
        tick();
        check("rw.no_read_after", 32'(avm_read), 32'h0);
        check("rw.write_done", 32'(avm_write), 32'h0);
        tick();
        check("rw.no_read_later", 32'(avm_read), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
